ds18b20_bcd_conv: RTL and testbench

//  Downstream of the DS18B20 driver. Consumes its sign-magnitude temperature word.

---
 rtl/temp_disp_pkg.sv | 31 +++
 rtl/bin2bcd_seq.sv | 49 ++++
 rtl/ds18b20_bcd_conv.sv | 111 +++++++++++
 tb/tb_ds18b20_bcd_conv.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/temp_disp_pkg.sv
// Shared types, constants and helpers for the DS18B20 temperature-to-BCD display path.
package temp_disp_pkg;

  localparam int unsigned MAG_W      = 11;
  localparam int unsigned BIN_W      = 21;
  localparam int unsigned MUL_625    = 625;
  localparam int unsigned RND_ADD    = 50;
  localparam int unsigned BCD_DIGITS = 7;
  localparam int unsigned OUT_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sample_t;

  // mag * 625 without a multiplier: 625 = 512 + 64 + 32 + 16 + 1
  function automatic logic [BIN_W-1:0] mul625(input logic [MAG_W-1:0] m);
    logic [BIN_W-1:0] w;
    w = BIN_W'(m);
    return (w << 9) + (w << 6) + (w << 5) + (w << 4) + w;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit per cycle into a packed BCD register.
module bin2bcd_seq
  import temp_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done_c
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_r;
  logic [CNT_W-1:0] cnt;
  logic             active;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Last shift happens on the edge where done_c is high.
  assign done_c = active && (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_r  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      bin_r  <= bin;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      {bcd, bin_r} <= {add3(bcd), bin_r} << 1;
      cnt          <= cnt + CNT_W'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/ds18b20_bcd_conv.sv
// Converts the DS18B20 sign-magnitude word into HHH.hh BCD digits with a valid pulse.
// Optional macro ROUND_EN rounds to the nearest hundredth instead of truncating.
module ds18b20_bcd_conv
  import temp_disp_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_data,
  input  logic        sign,
  output logic [3:0]  bcd_hund,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [3:0]  bcd_tenth,
  output logic [3:0]  bcd_hundth,
  output logic        neg,
  output logic        busy,
  output logic        valid
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

  sample_t          cur, smp, last;
  logic [CNT_W-1:0] stab_cnt;
  state_t           state, state_nxt;
  logic             start_c;
  logic             conv_done_c;
  logic [BIN_W-1:0] prod_c;
  logic [BCD_W-1:0] bcd;
  logic             unused_bits;

  assign cur         = sample_t'({sign, temp_data[MAG_W-1:0]});
  assign unused_bits = ^{temp_data[15:MAG_W], bcd[7:0]};

`ifdef ROUND_EN
  assign prod_c = mul625(last.mag) + BIN_W'(RND_ADD);
`else
  assign prod_c = mul625(last.mag);
`endif

  // Input sampling and stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp      <= '0;
      stab_cnt <= '0;
    end else begin
      smp <= cur;
      if (cur != smp)                              stab_cnt <= '0;
      else if (stab_cnt != CNT_W'(STABLE_CNT))     stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    unique case (state)
      IDLE:    if (stab_cnt == CNT_W'(STABLE_CNT) && smp != last) state_nxt = MULT;
      MULT: begin
        start_c   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT:   if (conv_done_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .bin    (prod_c),
    .bcd    (bcd),
    .done_c (conv_done_c)
  );

  // Latched sample, status and output digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last       <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      neg        <= 1'b0;
      bcd_hund   <= '0;
      bcd_tens   <= '0;
      bcd_ones   <= '0;
      bcd_tenth  <= '0;
      bcd_hundth <= '0;
    end else begin
      valid <= 1'b0;
      busy  <= (state_nxt != IDLE);
      if (state == IDLE && state_nxt == MULT) last <= smp;
      if (state == DONE) begin
        bcd_hund   <= bcd[27:24];
        bcd_tens   <= bcd[23:20];
        bcd_ones   <= bcd[19:16];
        bcd_tenth  <= bcd[15:12];
        bcd_hundth <= bcd[11:8];
        neg        <= last.sign & (last.mag != '0);
        valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_bcd_conv.sv
// Scoreboard bench for ds18b20_bcd_conv; honours ROUND_EN for expected digits.
module tb_ds18b20_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] temp_data;
  logic        sign;
  logic [3:0]  bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth;
  logic        neg, busy, valid;

  typedef struct packed {
    logic [19:0] digits;
    logic        n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   nvalid = 0;
  logic busy_q = 1'b0;

  ds18b20_bcd_conv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_data  (temp_data),
    .sign       (sign),
    .bcd_hund   (bcd_hund),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .bcd_tenth  (bcd_tenth),
    .bcd_hundth (bcd_hundth),
    .neg        (neg),
    .busy       (busy),
    .valid      (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected results on every valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_q) rise_cyc = cyc;
    busy_q = busy;
    if (valid) begin
      nvalid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'(0));
      end else begin
        e = q.pop_front();
        chk("digits", 32'({bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth}), 32'(e.digits));
        chk("neg", 32'(neg), 32'(e.n));
        chk("latency", 32'(cyc - rise_cyc), 32'(23));
      end
    end
  end

  task automatic set_in(input logic [15:0] d, input logic s);
    @(posedge clk);
    #1;
    temp_data = d;
    sign      = s;
  endtask

  task automatic push(input logic [19:0] d, input logic n);
    exp_t e;
    e.digits = d;
    e.n      = n;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_digits"}, 32'({bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth}), 32'(0));
    chk({tag, "_neg"}, 32'(neg), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int v0;
    rst_n     = 1'b0;
    temp_data = 16'h0000;
    sign      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: zero input after reset never converts
    repeat (50) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    chk("reset_nvalid", 32'(nvalid), 32'(0));

    // 2: 25.0625 degC
    push(20'h02506, 1'b0);
    set_in(16'h0191, 1'b0);
    wait_drain();

    // 3: -10.125 degC, upper bits ignored
`ifdef ROUND_EN
    push(20'h01013, 1'b1);
`else
    push(20'h01012, 1'b1);
`endif
    set_in(16'hF8A2, 1'b1);
    wait_drain();

    // 4: full-scale magnitude
`ifdef ROUND_EN
    push(20'h12794, 1'b0);
`else
    push(20'h12793, 1'b0);
`endif
    set_in(16'h07FF, 1'b0);
    wait_drain();

    // 6: reset during SHIFT aborts, then reconverts
    set_in(16'h0191, 1'b0);
    for (int i = 0; i < 50 && !busy; i++) @(posedge clk);
    #1;
    chk("abort_busy_seen", 32'(busy), 32'(1));
    v0 = nvalid;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_zero_outputs("abort");
    push(20'h02506, 1'b0);
    wait_drain();
    chk("abort_nvalid", 32'(nvalid - v0), 32'(1));

    // 5: short glitch on an already converted value
    v0 = nvalid;
    set_in(16'h0192, 1'b0);
    set_in(16'h0191, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    chk("glitch_nvalid", 32'(nvalid - v0), 32'(0));
    chk("glitch_hold", 32'({bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth}), 32'(20'h02506));

    // 7: negative zero shows as 000.00 positive
    push(20'h00000, 1'b0);
    set_in(16'h0000, 1'b1);
    wait_drain();

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
